// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - types and constants for the USB packet transmitter
`include "usb_defs.vh"

package usb_tx_pkg;

    // Line state as {dp, dn}
    typedef enum logic [1:0] {
        LINE_SE0 = `USB_LINE_SE0,
        LINE_K   = `USB_LINE_K,
        LINE_J   = `USB_LINE_J
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    localparam logic [7:0] SYNC_PATTERN           = `USB_SYNC_PATTERN;
    localparam logic [2:0] MAX_RUN_LENGTH         = `USB_MAX_RUN;
    localparam int         DEFAULT_CLOCKS_PER_BIT = `USB_CLOCKS_PER_BIT;

    // A transmitted 0 flips the differential level between J and K
    function automatic line_t nrzi_toggle(input line_t level);
        return (level == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_defs.vh
// rtl/usb_defs.vh - full-speed USB line-level constants shared by transmit and receive paths
`ifndef USB_DEFS_VH
`define USB_DEFS_VH

`define USB_LINE_SE0          2'b00
`define USB_LINE_K            2'b01
`define USB_LINE_J            2'b10
`define USB_SYNC_PATTERN      8'h80
`define USB_MAX_RUN           3'd6
`define USB_CLOCKS_PER_BIT    4

`endif

// File: rtl/usb_tx_bit_encoder.sv
// rtl/usb_tx_bit_encoder.sv - NRZI encoder with bit stuffing, one line bit per strobe
module usb_tx_bit_encoder
    import usb_tx_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  bit_strobe,
    input  logic  bit_valid,
    input  logic  data_bit,
    input  line_t force_state,
    output line_t line_state,
    output logic  stall
);

    logic [2:0] ones;

    // A full run of ones means the next strobe must carry a stuff bit instead of data
    assign stall = (ones == MAX_RUN_LENGTH);

    // Line register: stuff bit has priority, then NRZI data, otherwise a forced level (SE0/J)
    always_ff @(posedge clock) begin
        if (reset) begin
            line_state <= LINE_J;
            ones       <= 3'd0;
        end else if (bit_strobe) begin
            if (stall) begin
                line_state <= nrzi_toggle(line_state);
                ones       <= 3'd0;
            end else if (bit_valid) begin
                if (data_bit) begin
                    ones <= ones + 3'd1;
                end else begin
                    line_state <= nrzi_toggle(line_state);
                    ones       <= 3'd0;
                end
            end else begin
                line_state <= force_state;
                ones       <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - full-speed USB packet transmitter: SYNC, stuffed NRZI payload, EOP
module usb_tx
    import usb_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       usb_dp_out,
    output logic       usb_dn_out,
    output logic       usb_oe,
    output logic       busy,
    output logic       underrun
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCKS_PER_BIT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       idx, idx_next;
    logic             eop_second, eop_second_next;
    logic [7:0]       hold_data, shift_data;
    logic             hold_full, hold_last, shift_last;
    logic             load_shift;
    logic             underrun_next;
    logic             bit_end;
    logic             enc_strobe, enc_valid, enc_bit, enc_stall;
    line_t            enc_force;
    line_t            line_state;

    assign bit_end    = (bit_cnt == CNT_MAX);
    assign in_ready   = !hold_full && (state != ST_EOP_SE0) && (state != ST_EOP_J);
    assign usb_oe     = (state != ST_IDLE);
    assign busy       = usb_oe;
    assign usb_dp_out = line_state[1];
    assign usb_dn_out = line_state[0];

    // Holding register: filled by the handshake, emptied when moved into the shift register
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
            hold_last <= 1'b0;
        end else begin
            if (load_shift) begin
                hold_full <= 1'b0;
            end
            if (in_valid && in_ready) begin
                hold_full <= 1'b1;
                hold_data <= in_data;
                hold_last <= in_last;
            end
        end
    end

    // Shift register keeps the byte on the wire and whether it closes the packet
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_data <= 8'h00;
            shift_last <= 1'b0;
        end else if (load_shift) begin
            shift_data <= hold_data;
            shift_last <= hold_last;
        end
    end

    // Bit timer runs only while the bus is owned; it wraps at the end of every bit time
    always_ff @(posedge clock) begin
        if (reset || state == ST_IDLE) begin
            bit_cnt <= '0;
        end else if (bit_end) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // FSM state and per-state counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            eop_second <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            eop_second <= eop_second_next;
            underrun   <= underrun_next;
        end
    end

    // Next-state logic: chooses what the encoder puts on the line at each bit boundary
    always_comb begin
        state_next      = state;
        idx_next        = idx;
        eop_second_next = eop_second;
        load_shift      = 1'b0;
        underrun_next   = 1'b0;
        enc_strobe      = 1'b0;
        enc_valid       = 1'b1;
        enc_bit         = 1'b0;
        enc_force       = LINE_J;
        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    state_next = ST_SYNC;
                    idx_next   = 3'd0;
                    load_shift = 1'b1;
                    enc_strobe = 1'b1;
                    enc_bit    = SYNC_PATTERN[0];
                end
            end
            ST_SYNC: begin
                if (bit_end) begin
                    enc_strobe = 1'b1;
                    if (idx == 3'd7) begin
                        state_next = ST_DATA;
                        idx_next   = 3'd0;
                        enc_bit    = shift_data[0];
                    end else begin
                        idx_next = idx + 3'd1;
                        enc_bit  = SYNC_PATTERN[idx + 3'd1];
                    end
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    enc_strobe = 1'b1;
                    if (enc_stall) begin
                        // encoder emits the stuff bit; decisions wait for its end
                        idx_next = idx;
                    end else if (idx != 3'd7) begin
                        idx_next = idx + 3'd1;
                        enc_bit  = shift_data[idx + 3'd1];
                    end else if (shift_last) begin
                        state_next      = ST_EOP_SE0;
                        eop_second_next = 1'b0;
                        enc_valid       = 1'b0;
                        enc_force       = LINE_SE0;
                    end else if (hold_full) begin
                        load_shift = 1'b1;
                        idx_next   = 3'd0;
                        enc_bit    = hold_data[0];
                    end else begin
                        underrun_next   = 1'b1;
                        state_next      = ST_EOP_SE0;
                        eop_second_next = 1'b0;
                        enc_valid       = 1'b0;
                        enc_force       = LINE_SE0;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_end) begin
                    enc_strobe = 1'b1;
                    enc_valid  = 1'b0;
                    if (!eop_second) begin
                        eop_second_next = 1'b1;
                        enc_force       = LINE_SE0;
                    end else begin
                        state_next = ST_EOP_J;
                        enc_force  = LINE_J;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_end) begin
                    enc_strobe = 1'b1;
                    enc_valid  = 1'b0;
                    enc_force  = LINE_J;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    usb_tx_bit_encoder u_encoder (
        .clock       (clock),
        .reset       (reset),
        .bit_strobe  (enc_strobe),
        .bit_valid   (enc_valid),
        .data_bit    (enc_bit),
        .force_state (enc_force),
        .line_state  (line_state),
        .stall       (enc_stall)
    );

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - self-checking bench for usb_tx
module tb_usb_tx;

    localparam int CPB = 4;
    localparam logic [1:0] L_J   = 2'b10;
    localparam logic [1:0] L_K   = 2'b01;
    localparam logic [1:0] L_SE0 = 2'b00;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       usb_dp_out;
    logic       usb_dn_out;
    logic       usb_oe;
    logic       busy;
    logic       underrun;

    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] exp_q[$];
    logic [7:0] pkt[0:3];
    logic [1:0] m_line;
    int         m_ones;

    usb_tx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .usb_dp_out (usb_dp_out),
        .usb_dn_out (usb_dn_out),
        .usb_oe     (usb_oe),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_string(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "K":     exp_q.push_back(L_K);
                "J":     exp_q.push_back(L_J);
                default: exp_q.push_back(L_SE0);
            endcase
        end
    endtask

    task automatic m_push(input bit b);
        if (!b) m_line = (m_line == L_J) ? L_K : L_J;
        exp_q.push_back(m_line);
    endtask

    // Reference model: SYNC, LSB-first NRZI with stuffing after six ones, then EOP
    task automatic model_packet(input int nsent);
        bit b;
        exp_q.delete();
        m_line = L_J;
        m_ones = 0;
        for (int i = 0; i < 8; i++) begin
            b = (i == 7);
            m_push(b);
            m_ones = b ? m_ones + 1 : 0;
        end
        for (int k = 0; k < nsent; k++) begin
            for (int j = 0; j < 8; j++) begin
                b = pkt[k][j];
                m_push(b);
                m_ones = b ? m_ones + 1 : 0;
                if (m_ones == 6) begin
                    m_push(1'b0);
                    m_ones = 0;
                end
            end
        end
        exp_q.push_back(L_SE0);
        exp_q.push_back(L_SE0);
        exp_q.push_back(L_J);
    endtask

    task automatic drive_byte(input int p, input int nb);
        in_data  = pkt[p];
        in_last  = (p == nb - 1);
        in_valid = 1'b1;
    endtask

    // Runs one packet from the current negedge; checks every cycle against the scoreboard
    task automatic run_packet(input int nb, input int offer, input int abort_at,
                              input int exp_cycles_in, input int exp_ur_pos);
        int ptr = 0;
        int iter = 0;
        int accept_iter = -1;
        int exp_cycles;
        int k;
        bit done = 0;
        bit aborted = 0;
        bit accept;
        bit exp_oe;
        logic [1:0] exp_line;
        exp_cycles = (exp_cycles_in >= 0) ? exp_cycles_in : CPB * exp_q.size();
        if (offer > 0) drive_byte(0, nb);
        while (!done && !aborted && iter < 2000) begin
            k = iter - accept_iter - 2;
            exp_oe = (accept_iter >= 0) && (k >= 0) && (k < exp_cycles);
            exp_line = exp_oe ? ((exp_q.size() > 0) ? exp_q[0] : 2'bxx) : L_J;
            check("oe", usb_oe, exp_oe);
            check("busy", busy, exp_oe);
            check("line", {usb_dp_out, usb_dn_out}, exp_line);
            check("underrun", underrun, exp_oe && (k == exp_ur_pos));
            if (exp_oe && exp_line == L_SE0) check("in_ready_eop", in_ready, 1'b0);
            if (exp_oe && (k % CPB == CPB - 1) && exp_q.size() > 0) void'(exp_q.pop_front());
            if (accept_iter >= 0 && k >= exp_cycles) done = 1;
            if (iter == abort_at) aborted = 1;
            if (done || aborted) break;
            accept = in_valid && in_ready;
            if (accept && accept_iter < 0) accept_iter = iter;
            @(posedge clock);
            #1;
            if (accept) begin
                ptr++;
                if (ptr < offer) drive_byte(ptr, nb);
                else in_valid = 1'b0;
            end
            @(negedge clock);
            iter++;
        end
        if (aborted) begin
            reset    = 1'b1;
            in_valid = 1'b0;
            @(posedge clock);
            #1;
            check("rst_oe", usb_oe, 1'b0);
            check("rst_line", {usb_dp_out, usb_dn_out}, L_J);
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_busy", busy, 1'b0);
            reset = 1'b0;
            exp_q.delete();
            @(negedge clock);
        end else begin
            check("completed", done, 1'b1);
            check("queue_drained", exp_q.size(), 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_oe", usb_oe, 1'b0);
        check("reset_line", {usb_dp_out, usb_dn_out}, L_J);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_underrun", underrun, 1'b0);
        reset = 1'b0;
        idle(2);

        // single byte A5
        pkt[0] = 8'hA5;
        load_string("KJKJKJKKKJJKJJKKSSJ");
        run_packet(1, 1, -1, 76, -1);
        idle(3);

        // single byte FF: stuff bit after fifth data bit
        pkt[0] = 8'hFF;
        load_string("KJKJKJKKKKKKKJJJJSSJ");
        run_packet(1, 1, -1, 80, -1);
        idle(3);

        // FC then 01: stuff bit at the byte boundary
        pkt[0] = 8'hFC;
        pkt[1] = 8'h01;
        model_packet(2);
        run_packet(2, 2, -1, 112, -1);
        idle(3);

        // underrun: second byte withheld
        pkt[0] = 8'h3C;
        pkt[1] = 8'h55;
        model_packet(1);
        run_packet(2, 1, -1, 76, 64);
        idle(3);

        // reset during byte 2 of a 3-byte packet, then a clean packet
        pkt[0] = 8'h12;
        pkt[1] = 8'h34;
        pkt[2] = 8'h56;
        model_packet(3);
        run_packet(3, 3, 76, -1, -1);
        idle(2);
        pkt[0] = 8'(($urandom_range(0, 255)));
        pkt[1] = 8'hC3;
        model_packet(2);
        run_packet(2, 2, -1, -1, -1);

        // back-to-back packets: second byte presented the cycle busy falls
        pkt[0] = 8'h7E;
        model_packet(1);
        run_packet(1, 1, -1, -1, -1);
        pkt[0] = 8'hF0;
        pkt[1] = 8'hFF;
        model_packet(2);
        run_packet(2, 2, -1, -1, -1);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
